// File: rtl/sp_bram_fifo.sv
// sp_bram_fifo: single-clock first-word-fall-through FIFO built on a simple
// dual-port block RAM. Port A is the write port. Port B is a registered read
// port, and that read register is also the output stage that holds the head word.
//
// Handshake (both sides): a word moves on a rising edge where valid && ready.
// wr_ready depends only on reset, clear and level, and never on rd_ready, so
// there is no combinational path from the read side to the write side.
// rd_valid and rd_data come straight from registers.
//
// Occupancy: level = ram_count + rd_valid, where ram_count is the number of
// words written to RAM that have not been fetched into the output register yet.
// A word is fetched no earlier than one edge after it was written, so the RAM
// never sees a read and a write to the same address in the same cycle.
`timescale 1ns/1ps

module sp_bram_fifo #(
    parameter int DW       = 36,
    parameter int DEPTH    = 512,
    parameter int AW       = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level,
    output logic          almost_full,
    output logic          almost_empty
);

    // Thresholds resized to the level width so every compare is same-width.
    localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0] L_AF    = AF_LEVEL[AW:0];
    localparam logic [AW:0] L_AE    = AE_LEVEL[AW:0];

    // Storage. It has no reset, so clear leaves the old contents in place.
    logic [DW-1:0] r_mem [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_ram_count;
    logic [AW:0]   r_level;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          r_almost_full;
    logic          r_almost_empty;

    logic          w_push;
    logic          w_pop;
    logic          w_fetch;
    logic [AW:0]   w_ram_count_next;
    logic [AW:0]   w_level_next;

    // A push while full is impossible even if a pop happens in the same cycle.
    assign wr_ready = !reset && !clear && (r_level < L_DEPTH);
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = r_rd_valid && rd_ready && !clear;
    // The output stage is refilled from RAM when it is empty or its word is leaving.
    assign w_fetch  = !clear && (r_ram_count != '0) && (!r_rd_valid || rd_ready);

    // Next-state arithmetic for the RAM-resident count and the total level.
    always_comb begin
        w_ram_count_next = r_ram_count;
        w_level_next     = r_level;
        case ({w_push, w_fetch})
            2'b10:   w_ram_count_next = r_ram_count + 1'b1;
            2'b01:   w_ram_count_next = r_ram_count - 1'b1;
            default: w_ram_count_next = r_ram_count;
        endcase
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // RAM write port A.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // RAM read port B. Its output register holds the head word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_fetch) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Pointers, counts, output-valid and threshold flags. Clear acts like reset here.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_ram_count    <= '0;
            r_level        <= '0;
            r_rd_valid     <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fetch) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_rd_valid <= 1'b1;
            end else if (w_pop) begin
                r_rd_valid <= 1'b0;
            end
            r_ram_count    <= w_ram_count_next;
            r_level        <= w_level_next;
            r_almost_full  <= (w_level_next >= L_AF);
            r_almost_empty <= (w_level_next <= L_AE);
        end
    end

    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign level        = r_level;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

endmodule

// File: tb/tb_sp_bram_fifo.sv
// Testbench for sp_bram_fifo. Instance A uses the default geometry (36 x 512).
// Instance B uses a small geometry (8 x 16) for random handshake traffic.
`timescale 1ns/1ps

module tb_sp_bram_fifo;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_clear, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready;
    logic [35:0] a_wr_data, a_rd_data;
    logic [9:0]  a_level;
    logic        a_almost_full, a_almost_empty;

    logic        b_clear, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
    logic [7:0]  b_wr_data, b_rd_data;
    logic [4:0]  b_level;
    logic        b_almost_full, b_almost_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    sp_bram_fifo u_a (
        .clk(clk), .reset(reset), .clear(a_clear),
        .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_data(a_wr_data),
        .rd_valid(a_rd_valid), .rd_ready(a_rd_ready), .rd_data(a_rd_data),
        .level(a_level), .almost_full(a_almost_full), .almost_empty(a_almost_empty)
    );

    sp_bram_fifo #(.DW(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) u_b (
        .clk(clk), .reset(reset), .clear(b_clear),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data),
        .level(b_level), .almost_full(b_almost_full), .almost_empty(b_almost_empty)
    );

    // Advance to just after the next rising edge. Inputs are driven and outputs sampled here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_clear = 1'b0; a_wr_valid = 1'b0; a_rd_ready = 1'b0; a_wr_data = '0;
        b_clear = 1'b0; b_wr_valid = 1'b0; b_rd_ready = 1'b0; b_wr_data = '0;
        tick; tick;
        n_checks++; if (a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready_in_reset: got %b expected 0", a_wr_ready); end
        n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", a_rd_valid); end
        n_checks++; if (a_rd_data !== 36'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", a_rd_data); end
        n_checks++; if (a_level !== 10'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", a_level); end
        n_checks++; if (a_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b expected 0", a_almost_full); end
        n_checks++; if (a_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b expected 1", a_almost_empty); end
        n_checks++; if (b_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_b_almost_empty: got %b expected 1", b_almost_empty); end
        reset = 1'b0;
        #1;
        n_checks++; if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready_after: got %b expected 1", a_wr_ready); end
        n_checks++; if (b_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_wr_ready_after: got %b expected 1", b_wr_ready); end
    endtask

    task automatic test_basic;
        a_rd_ready = 1'b0;
        a_wr_valid = 1'b1; a_wr_data = 36'h000000001;
        tick;
        n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet_valid: got %b expected 0", a_rd_valid); end
        n_checks++; if (a_level !== 10'd1) begin n_fail++; $display("FAIL basic_level1: got %0d expected 1", a_level); end
        a_wr_data = 36'h000000002;
        tick;
        n_checks++; if (a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid: got %b expected 1", a_rd_valid); end
        n_checks++; if (a_rd_data !== 36'h000000001) begin n_fail++; $display("FAIL basic_first_data: got %h expected 1", a_rd_data); end
        a_wr_data = 36'h000000003;
        tick;
        a_wr_valid = 1'b0;
        n_checks++; if (a_level !== 10'd3) begin n_fail++; $display("FAIL basic_level3: got %0d expected 3", a_level); end
        n_checks++; if (a_almost_empty !== 1'b1) begin n_fail++; $display("FAIL basic_almost_empty: got %b expected 1", a_almost_empty); end
        a_rd_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            n_checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 36'(i)) begin n_fail++; $display("FAIL basic_pop%0d: got valid=%b data=%h expected valid=1 data=%h", i, a_rd_valid, a_rd_data, 36'(i)); end
            tick;
        end
        a_rd_ready = 1'b0;
        n_checks++; if (a_rd_valid !== 1'b0 || a_level !== 10'd0) begin n_fail++; $display("FAIL basic_empty: got valid=%b level=%0d expected 0/0", a_rd_valid, a_level); end
    endtask

    task automatic test_fill;
        int exp;
        a_rd_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            a_wr_valid = 1'b1; a_wr_data = 36'(i);
            n_checks++; if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_wr_ready at %0d: got %b expected 1", i, a_wr_ready); end
            tick;
            n_checks++; if (a_level !== 10'(i + 1)) begin n_fail++; $display("FAIL fill_level: got %0d expected %0d", a_level, i + 1); end
            n_checks++; if (a_almost_full !== ((i + 1) >= 508)) begin n_fail++; $display("FAIL fill_almost_full at level %0d: got %b expected %b", i + 1, a_almost_full, (i + 1) >= 508); end
            n_checks++; if (a_almost_empty !== ((i + 1) <= 4)) begin n_fail++; $display("FAIL fill_almost_empty at level %0d: got %b expected %b", i + 1, a_almost_empty, (i + 1) <= 4); end
        end
        // Attempt a push while full.
        a_wr_data = 36'h999;
        n_checks++; if (a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %b expected 0", a_wr_ready); end
        tick;
        a_wr_valid = 1'b0;
        n_checks++; if (a_level !== 10'd512) begin n_fail++; $display("FAIL full_push_rejected: got level %0d expected 512", a_level); end
        a_rd_ready = 1'b1;
        n_checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 36'd0) begin n_fail++; $display("FAIL full_head: got valid=%b data=%h expected 1/0", a_rd_valid, a_rd_data); end
        tick;
        n_checks++; if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_restores_ready: got %b expected 1", a_wr_ready); end
        n_checks++; if (a_level !== 10'd511) begin n_fail++; $display("FAIL full_pop_level: got %0d expected 511", a_level); end
        exp = 1;
        for (int c = 0; c < 600 && a_level != 10'd0; c++) begin
            if (a_rd_valid) begin
                n_checks++; if (a_rd_data !== 36'(exp)) begin n_fail++; $display("FAIL drain_data: got %h expected %h", a_rd_data, 36'(exp)); end
                exp++;
            end
            tick;
        end
        a_rd_ready = 1'b0;
        n_checks++; if (exp != 512) begin n_fail++; $display("FAIL drain_count: got %0d words expected 512", exp); end
        n_checks++; if (a_level !== 10'd0 || a_almost_full !== 1'b0) begin n_fail++; $display("FAIL drain_end: got level=%0d af=%b expected 0/0", a_level, a_almost_full); end
    endtask

    task automatic test_back_to_back;
        int in_k;
        int out_k;
        a_rd_ready = 1'b0;
        a_wr_valid = 1'b1; a_wr_data = 36'd0; tick;
        a_wr_data = 36'd1; tick;
        in_k = 2; out_k = 0;
        a_rd_ready = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            a_wr_data = 36'(in_k * 7 + 36'h500000000);
            if (out_k >= 2) begin
                n_checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 36'(out_k * 7 + 36'h500000000)) begin n_fail++; $display("FAIL stream_data at %0d: got valid=%b data=%h expected %h", c, a_rd_valid, a_rd_data, 36'(out_k * 7 + 36'h500000000)); end
            end else begin
                n_checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 36'(out_k)) begin n_fail++; $display("FAIL stream_head at %0d: got valid=%b data=%h expected %h", c, a_rd_valid, a_rd_data, 36'(out_k)); end
            end
            out_k++; in_k++;
            tick;
            n_checks++; if (a_level !== 10'd2) begin n_fail++; $display("FAIL stream_level at %0d: got %0d expected 2", c, a_level); end
        end
        a_wr_valid = 1'b0;
        for (int c = 0; c < 10 && a_level != 10'd0; c++) begin
            if (a_rd_valid) begin
                n_checks++; if (a_rd_data !== 36'(out_k * 7 + 36'h500000000)) begin n_fail++; $display("FAIL stream_tail: got %h expected %h", a_rd_data, 36'(out_k * 7 + 36'h500000000)); end
                out_k++;
            end
            tick;
        end
        a_rd_ready = 1'b0;
        n_checks++; if (out_k != 2002 || a_level !== 10'd0) begin n_fail++; $display("FAIL stream_total: got %0d words level=%0d expected 2002/0", out_k, a_level); end
    endtask

    task automatic test_level_one;
        a_rd_ready = 1'b0;
        a_wr_valid = 1'b1; a_wr_data = 36'h11; tick;
        a_wr_valid = 1'b0; tick;
        n_checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 36'h11 || a_level !== 10'd1) begin n_fail++; $display("FAIL lvl1_setup: got valid=%b data=%h level=%0d expected 1/11/1", a_rd_valid, a_rd_data, a_level); end
        a_wr_valid = 1'b1; a_wr_data = 36'h22; a_rd_ready = 1'b1;
        tick;
        a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL lvl1_bubble: got valid=%b expected 0", a_rd_valid); end
        n_checks++; if (a_level !== 10'd1) begin n_fail++; $display("FAIL lvl1_level: got %0d expected 1", a_level); end
        tick;
        n_checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 36'h22) begin n_fail++; $display("FAIL lvl1_refetch: got valid=%b data=%h expected 1/22", a_rd_valid, a_rd_data); end
        n_checks++; if (a_level !== 10'd1) begin n_fail++; $display("FAIL lvl1_level_after: got %0d expected 1", a_level); end
        a_rd_ready = 1'b1; tick; a_rd_ready = 1'b0;
        n_checks++; if (a_level !== 10'd0) begin n_fail++; $display("FAIL lvl1_drain: got %0d expected 0", a_level); end
    endtask

    task automatic test_clear;
        a_rd_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            a_wr_valid = 1'b1; a_wr_data = 36'(i + 36'h300); tick;
        end
        n_checks++; if (a_level !== 10'd100) begin n_fail++; $display("FAIL clear_setup: got level %0d expected 100", a_level); end
        a_clear = 1'b1; a_wr_valid = 1'b1; a_wr_data = 36'h777; a_rd_ready = 1'b1;
        #1;
        n_checks++; if (a_wr_ready !== 1'b0) begin n_fail++; $display("FAIL clear_wr_ready: got %b expected 0", a_wr_ready); end
        tick;
        a_clear = 1'b0; a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        n_checks++; if (a_level !== 10'd0) begin n_fail++; $display("FAIL clear_level: got %0d expected 0", a_level); end
        n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_rd_valid: got %b expected 0", a_rd_valid); end
        n_checks++; if (a_almost_empty !== 1'b1) begin n_fail++; $display("FAIL clear_almost_empty: got %b expected 1", a_almost_empty); end
        a_wr_valid = 1'b1; a_wr_data = 36'hABCDE; tick;
        a_wr_valid = 1'b0; tick;
        n_checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 36'hABCDE) begin n_fail++; $display("FAIL clear_first_read: got valid=%b data=%h expected 1/ABCDE", a_rd_valid, a_rd_data); end
        n_checks++; if (a_level !== 10'd1) begin n_fail++; $display("FAIL clear_level_after_push: got %0d expected 1", a_level); end
        a_rd_ready = 1'b1; tick; a_rd_ready = 1'b0;
    endtask

    task automatic test_random;
        int  cnt;
        bit  push;
        bit  pop;
        cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            b_wr_valid = 1'($urandom_range(0, 1));
            b_rd_ready = 1'($urandom_range(0, 1));
            b_wr_data  = 8'($urandom_range(0, 255));
            #1;
            n_checks++; if (b_wr_ready !== (cnt < 16)) begin n_fail++; $display("FAIL rnd_wr_ready at %0d: got %b expected %b", c, b_wr_ready, cnt < 16); end
            push = b_wr_valid && (cnt < 16);
            pop  = b_rd_valid && b_rd_ready;
            if (pop) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_pop_empty at %0d: got data=%h expected no valid word", c, b_rd_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (b_rd_data !== e) begin n_fail++; $display("FAIL rnd_data at %0d: got %h expected %h", c, b_rd_data, e); end
                end
            end
            if (push) exp_q.push_back(b_wr_data);
            cnt = cnt + int'(push) - int'(pop);
            tick;
            n_checks++; if (b_level !== 5'(cnt)) begin n_fail++; $display("FAIL rnd_level at %0d: got %0d expected %0d", c, b_level, cnt); end
            n_checks++; if (b_almost_full !== (cnt >= 12)) begin n_fail++; $display("FAIL rnd_almost_full at %0d: got %b expected %b", c, b_almost_full, cnt >= 12); end
            n_checks++; if (b_almost_empty !== (cnt <= 2)) begin n_fail++; $display("FAIL rnd_almost_empty at %0d: got %b expected %b", c, b_almost_empty, cnt <= 2); end
        end
        b_wr_valid = 1'b0; b_rd_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            if (b_rd_valid) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_checks++; if (b_rd_data !== e) begin n_fail++; $display("FAIL rnd_drain_data: got %h expected %h", b_rd_data, e); end
            end
            tick;
        end
        b_rd_ready = 1'b0;
        n_checks++; if (exp_q.size() != 0 || b_level !== 5'd0) begin n_fail++; $display("FAIL rnd_drain_end: got %0d words left level=%0d expected 0/0", exp_q.size(), b_level); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_fill;
        test_back_to_back;
        test_level_one;
        test_clear;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Overall time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
